// File: rtl/sram_ctrl.sv
// Single-request bus master for the asynchronous 8Kx8 SRAM: sequences cs_n/rw_n/oe_n with programmable setup/pulse/hold.
// The FSM decodes strobes combinationally; every SRAM-side pin is re-registered, so the pins trail the FSM by one cycle.
module sram_ctrl #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              sram_cs_n,
  output logic              sram_rw_n,
  output logic              sram_oe_n,
  output logic [ADDR_W-1:0] sram_a,
  inout  wire  [DATA_W-1:0] sram_d
);

  typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, HOLD} state_t;

  state_t            state, state_nx;
  logic [7:0]        cnt, cnt_nx;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              accept;

  logic              cs_n_d, rw_n_d, oe_n_d, d_oe_d, rsp_d;
  logic              d_oe;
  logic [DATA_W-1:0] d_out;

  assign req_ready = rst_n && (state == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = SETUP;
          cnt_nx   = 8'(SETUP_CYC);
        end
      end
      SETUP: begin
        if (cnt == 8'd1) begin
          state_nx = ACTIVE;
          cnt_nx   = 8'(PULSE_CYC);
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      ACTIVE: begin
        if (cnt == 8'd1) begin
          state_nx = HOLD;
          cnt_nx   = 8'(HOLD_CYC);
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      HOLD: begin
        if (cnt == 8'd1) begin
          state_nx = IDLE;
          cnt_nx   = 8'd0;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 8'd0;
      end
    endcase
  end

  // Write data drive spans SETUP..HOLD; oe_n only ever falls on reads, so the two never overlap.
  always_comb begin
    cs_n_d = !(state == ACTIVE);
    rw_n_d = !((state == ACTIVE) && we_q);
    oe_n_d = !((state == ACTIVE) && !we_q);
    d_oe_d = we_q && (state != IDLE);
    rsp_d  = (state == HOLD) && (cnt == 8'(HOLD_CYC));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // The read capture edge is the one where the pins leave ACTIVE, i.e. the FSM's first HOLD cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sram_cs_n <= 1'b1;
      sram_rw_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_a    <= '0;
      d_oe      <= 1'b0;
      d_out     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      sram_cs_n <= cs_n_d;
      sram_rw_n <= rw_n_d;
      sram_oe_n <= oe_n_d;
      sram_a    <= addr_q;
      d_oe      <= d_oe_d;
      d_out     <= wdata_q;
      rsp_valid <= rsp_d;
      if (rsp_d && !we_q) begin
        rsp_rdata <= sram_d;
      end
    end
  end

  assign sram_d = d_oe ? d_out : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// Drives two controllers (default timing and 2/3/2 timing) against an SRAM device model and a timeline/memory reference.
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [12:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        sel = 1'b0;

  always #5 clk = ~clk;

  logic        rdy0, rsp0, cs0, rw0, oe0;
  logic        rdy1, rsp1, cs1, rw1, oe1;
  logic [7:0]  rd0, rd1;
  logic [12:0] a0, a1;
  wire  [7:0]  d0, d1;
  logic        rv0, rv1;

  assign rv0 = req_valid && !sel;
  assign rv1 = req_valid && sel;

  sram_ctrl u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv0), .req_ready(rdy0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp0), .rsp_rdata(rd0),
    .sram_cs_n(cs0), .sram_rw_n(rw0), .sram_oe_n(oe0), .sram_a(a0), .sram_d(d0)
  );

  sram_ctrl #(.SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_ready(rdy1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp1), .rsp_rdata(rd1),
    .sram_cs_n(cs1), .sram_rw_n(rw1), .sram_oe_n(oe1), .sram_a(a1), .sram_d(d1)
  );

  // SRAM device model: drives the bus while selected with oe_n low, stores on clock edges with cs_n and rw_n low.
  logic [7:0] dev_mem [8192];
  assign d0 = (!cs0 && !oe0) ? dev_mem[a0] : 8'bz;
  assign d1 = (!cs1 && !oe1) ? dev_mem[a1] : 8'bz;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8192; i++) dev_mem[i] <= 8'(i) ^ 8'h5A;
    end else begin
      if (!cs0 && !rw0) dev_mem[a0] <= d0;
      if (!cs1 && !rw1) dev_mem[a1] <= d1;
    end
  end

  wire        req_ready = sel ? rdy1 : rdy0;
  wire        rsp_valid = sel ? rsp1 : rsp0;
  wire [7:0]  rsp_rdata = sel ? rd1  : rd0;
  wire        cs_n      = sel ? cs1  : cs0;
  wire        rw_n      = sel ? rw1  : rw0;
  wire        oe_n      = sel ? oe1  : oe0;
  wire [12:0] sram_a    = sel ? a1   : a0;
  wire [7:0]  sram_d    = sel ? d1   : d0;
  wire        d_oe      = sel ? u1.d_oe : u0.d_oe;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int npass = 0;
  int ntot  = 0;
  logic [7:0] ref_mem [8192];
  logic [7:0] last_rd [2];
  int  prev_acc = 0;
  bit  prev_keep = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // One request, then a cycle-by-cycle comparison of the pins against the setup/pulse/hold timeline.
  task automatic txn(input bit we, input logic [12:0] addr, input logic [7:0] wd, input bit keep);
    int s, p, h, n;
    bit got, act;
    logic [7:0] exp_rd;
    s = sel ? 2 : 1;
    p = sel ? 3 : 2;
    h = sel ? 2 : 1;
    n = s + p + h;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1;
        break;
      end
    end
    chk("accept_timeout", 32'(got), 32'd1);
    if (!got) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (prev_keep) chk("accept_spacing", 32'(cyc - prev_acc), 32'(1 + n));
    prev_acc  = cyc;
    prev_keep = keep;
    chk("accept_cs_n", 32'(cs_n), 32'd1);
    chk("accept_drive_released", 32'(d_oe), 32'd0);
    chk("accept_rsp_valid", 32'(rsp_valid), 32'd0);
    exp_rd = we ? last_rd[sel] : ref_mem[addr];
    if (we) ref_mem[addr] = wd;
    else last_rd[sel] = exp_rd;
    if (keep) begin
      req_we    = 1'($urandom);
      req_addr  = 13'($urandom);
      req_wdata = 8'($urandom);
    end else begin
      req_valid = 1'b0;
    end
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      act = (k > s) && (k <= s + p);
      chk("cs_n", 32'(cs_n), 32'(!act));
      chk("rw_n", 32'(rw_n), 32'(!(act && we)));
      chk("oe_n", 32'(oe_n), 32'(!(act && !we)));
      chk("sram_a", 32'(sram_a), 32'(addr));
      chk("drive_enable", 32'(d_oe), 32'(we));
      chk("rsp_valid", 32'(rsp_valid), 32'(k == s + p + 1));
      chk("req_ready", 32'(req_ready), 32'(k == n));
      if (k == s + p + 1) chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
      if (we) chk("sram_d", 32'(sram_d), 32'(wd));
    end
  endtask

  initial begin
    logic [12:0] pool [5];
    pool[0] = 13'h005; pool[1] = 13'h00C; pool[2] = 13'h100; pool[3] = 13'h1FFF; pool[4] = 13'h777;
    for (int i = 0; i < 8192; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_rw_n", 32'(rw_n), 32'd1);
    chk("rst_oe_n", 32'(oe_n), 32'd1);
    chk("rst_sram_a", 32'(sram_a), 32'd0);
    chk("rst_drive", 32'(d_oe), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // Directed write and read-back, then a held-valid write/read pair.
    txn(1'b1, 13'h005, 8'h3C, 1'b0);
    txn(1'b0, 13'h005, 8'h00, 1'b0);
    txn(1'b1, 13'h00C, 8'hA5, 1'b1);
    txn(1'b0, 13'h00C, 8'h00, 1'b0);

    for (int i = 0; i < 16; i++) begin
      txn(1'($urandom), pool[$urandom_range(0, 4)], 8'($urandom), (i != 15) && 1'($urandom));
      if (!prev_keep) repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    sel = 1'b1;
    prev_keep = 0;
    txn(1'b1, 13'h1FFF, 8'h5A, 1'b1);
    txn(1'b0, 13'h1FFF, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      txn(1'($urandom), pool[$urandom_range(0, 4)], 8'($urandom), (i != 5) && 1'($urandom));
    end

    // Reset while a write is in its ACTIVE phase.
    sel = 1'b0;
    prev_keep = 0;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 13'h0AA;
    req_wdata = 8'hC3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_active_cs_n", 32'(cs_n), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_cs_n", 32'(cs_n), 32'd1);
    chk("abort_rw_n", 32'(rw_n), 32'd1);
    chk("abort_oe_n", 32'(oe_n), 32'd1);
    chk("abort_drive", 32'(d_oe), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("abort_ready_held", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("abort_ready_back", 32'(req_ready), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
      chk("abort_cs_idle", 32'(cs_n), 32'd1);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
